hvac_sequencer: RTL

HVAC_SEQUENCER -- requirements
Module: hvac_sequencer

---
 rtl/hvac_pkg.sv | 12 +
 rtl/hvac_tick_timer.sv | 16 +
 rtl/hvac_sequencer.sv | 69 ++++++
 3 files changed

// File: rtl/hvac_pkg.sv
// hvac_pkg: shared state encoding and widths for the HVAC sequencer
package hvac_pkg;
  localparam int TW = 8;
  localparam int RW = 16;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAT  = 3'd1,
    S_COOL  = 3'd2,
    S_PURGE = 3'd3,
    S_LOCK  = 3'd4
  } state_t;
endpackage

// File: rtl/hvac_tick_timer.sv
// hvac_tick_timer: saturating tick counter, cleared on every state change
import hvac_pkg::*;
module hvac_tick_timer (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          tick,
  output logic [TW-1:0] count,
  output logic          saturated
);
  assign saturated = &count;
  // clear has priority over a coincident tick so a new state always starts at 0
  always_ff @(posedge clk)
    if (reset || clear) count <= '0;
    else if (tick && !saturated) count <= count + 1'b1;
endmodule

// File: rtl/hvac_sequencer.sv
// hvac_sequencer: heat/cool equipment sequencer with min-on, purge and lockout timing
import hvac_pkg::*;
module hvac_sequencer #(
  parameter int MIN_ON  = 3,
  parameter int MIN_OFF = 4,
  parameter int PURGE   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          heat_req,
  input  logic          cool_req,
  output logic          furnace_on,
  output logic          compressor_on,
  output logic          fan_on,
  output logic          req_conflict,
  output logic [2:0]    state,
  output logic [RW-1:0] run_count
);
  localparam logic [TW-1:0] ON_T  = TW'(MIN_ON);
  localparam logic [TW-1:0] OFF_T = TW'(MIN_OFF);
  localparam logic [TW-1:0] PG_T  = TW'(PURGE);
  state_t        st, nxt;
  logic [TW-1:0] cnt;
  logic          sat;
  logic          on_ok, off_ok, pg_ok;
  assign state  = st;
  assign on_ok  = sat || cnt >= ON_T;
  assign off_ok = sat || cnt >= OFF_T;
  assign pg_ok  = sat || cnt >= PG_T;
  hvac_tick_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (nxt != st),
    .tick     (tick),
    .count    (cnt),
    .saturated(sat)
  );
  // next-state decode; the opposite demand is ignored while running
  always_comb begin
    nxt = S_LOCK;
    case (st)
      S_IDLE:  nxt = (heat_req && !cool_req) ? S_HEAT : (cool_req && !heat_req) ? S_COOL : S_IDLE;
      S_HEAT:  nxt = (!heat_req && on_ok) ? S_PURGE : S_HEAT;
      S_COOL:  nxt = (!cool_req && on_ok) ? S_PURGE : S_COOL;
      S_PURGE: nxt = pg_ok ? S_LOCK : S_PURGE;
      S_LOCK:  nxt = off_ok ? S_IDLE : S_LOCK;
      default: nxt = S_LOCK;
    endcase
  end
  // state and drives update on the same edge so outputs always match state
  always_ff @(posedge clk)
    if (reset) begin
      st            <= S_LOCK;
      furnace_on    <= 1'b0;
      compressor_on <= 1'b0;
      fan_on        <= 1'b0;
      req_conflict  <= 1'b0;
      run_count     <= '0;
    end else begin
      st            <= nxt;
      furnace_on    <= nxt == S_HEAT;
      compressor_on <= nxt == S_COOL;
      fan_on        <= nxt inside {S_HEAT, S_COOL, S_PURGE};
      req_conflict  <= st == S_IDLE && heat_req && cool_req;
      if (st == S_IDLE && nxt inside {S_HEAT, S_COOL} && !(&run_count))
        run_count <= run_count + 1'b1;
    end
endmodule
